// File: rtl/cpu16_ctrl.sv
// Multi-cycle control unit for the 16-bit datapath: fetches over a req/ack port,
// decodes into ALU/register-file/data-memory controls and owns the PC.
module cpu16_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  output logic [3:0]        rf_waddr,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              b_sel,
  output logic [15:0]       imm,
  output logic [3:0]        alu_ctrl,
  input  logic              a_zero,
  input  logic              b_zero,
  output logic              halted,
  output logic              err
);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpMul  = 4'h5;
  localparam logic [3:0] OpNop  = 4'h6;
  localparam logic [3:0] OpDiv  = 4'h7;
  localparam logic [3:0] OpNot  = 4'h8;
  localparam logic [3:0] OpMod  = 4'h9;
  localparam logic [3:0] OpLdi  = 4'hA;
  localparam logic [3:0] OpLd   = 4'hB;
  localparam logic [3:0] OpSt   = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpBz   = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              err_q, err_d;

  logic [3:0]        op, rd, rs1, rs2;
  logic              is_alu, is_div;
  logic              active;
  logic [ADDR_W-1:0] pc_inc, br_off, jmp_tgt;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign rs1 = ir_q[7:4];
  assign rs2 = ir_q[3:0];

  assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign br_off  = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
  assign jmp_tgt = {{(ADDR_W-12){1'b0}}, ir_q[11:0]};

  always_comb begin
    is_alu = 1'b0;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpMul,
      OpDiv, OpNot, OpMod, OpLdi: is_alu = 1'b1;
      default:                    is_alu = 1'b0;
    endcase
  end

  assign is_div = (op == OpDiv) || (op == OpMod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_inc;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_alu) begin
          // Divide/modulo by zero suppresses writeback and stops the core.
          if (is_div && b_zero) begin
            err_d   = 1'b1;
            state_d = StHalted;
          end else begin
            state_d = StWb;
          end
        end else begin
          case (op)
            OpLd, OpSt: state_d = StMem;
            OpJmp: begin
              pc_d    = jmp_tgt;
              state_d = StFetch;
            end
            OpBz: begin
              // pc_q already points past the branch.
              if (a_zero) pc_d = pc_q + br_off;
              state_d = StFetch;
            end
            OpHalt:  state_d = StHalted;
            default: state_d = StFetch;
          endcase
        end
      end
      StMem: begin
        if (dmem_ack) state_d = (op == OpSt) ? StFetch : StWb;
      end
      StWb:     state_d = StFetch;
      StHalted: state_d = StHalted;
      default:  state_d = StFetch;
    endcase
  end

  assign active = (state_q == StDecode) || (state_q == StExec) ||
                  (state_q == StMem) || (state_q == StWb);

  always_comb begin
    // Gate with rst_n so the request drops the instant reset asserts.
    imem_req   = (state_q == StFetch) && rst_n;
    imem_addr  = pc_q;
    dmem_req   = (state_q == StMem);
    dmem_we    = (state_q == StMem) && (op == OpSt);
    rf_we      = (state_q == StWb);
    wb_sel     = ((state_q == StMem) || (state_q == StWb)) && (op == OpLd);
    b_sel      = active && (op == OpLdi);
    alu_ctrl   = (active && is_alu) ? op : 4'b0000;
    imm        = {8'h00, ir_q[7:0]};
    rf_raddr_a = (op == OpBz) ? rd : rs1;
    rf_raddr_b = (op == OpSt) ? rd : rs2;
    rf_waddr   = rd;
    halted     = (state_q == StHalted);
    err        = err_q;
  end

endmodule
